// File: rtl/fsic_io_serdes_pkg.sv
// Shared io_serdes definitions: lane word width, default training word,
// link-controller state encoding and a small saturating-counter helper.
package fsic_io_serdes_pkg;

    localparam int         CLK_RATIO = 4;
    localparam logic [3:0] TRAIN_PAT = 4'hA;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_TRAIN  = 3'd2,
        ST_LINK   = 3'd3,
        ST_OFF    = 3'd4,
        ST_FAIL   = 3'd5
    } state_t;

    function automatic logic [1:0] sat_inc2(input logic [1:0] v, input logic [1:0] lim);
        if (v >= lim) begin
            return v;
        end else begin
            return v + 2'd1;
        end
    endfunction

endpackage

// File: rtl/fsic_io_serdes_train_chk.sv
// Counts consecutive training-word matches; done_o flags the cycle on which
// the run reaches LEN (combinational, so the caller can act on the same edge).
import fsic_io_serdes_pkg::*;

module fsic_io_serdes_train_chk #(
    parameter int              W   = CLK_RATIO,
    parameter logic [W-1:0]    PAT = TRAIN_PAT,
    parameter int              LEN = 8,
    localparam int             CW  = $clog2(LEN + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          en_i,
    input  logic [W-1:0]  word_i,
    output logic          done_o,
    output logic [CW-1:0] match_cnt_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next match count: a mismatching valid word restarts the run, the run saturates at LEN.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            if (word_i != PAT) begin
                cnt_d = '0;
            end else if (cnt_q == CW'(LEN)) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Match counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o      = !clr_i && (cnt_d == CW'(LEN));
    assign match_cnt_o = cnt_q;

endmodule

// File: rtl/fsic_io_serdes_rx_link_ctrl.sv
// RX lane bring-up sequencer: settle, train, link, bounded retry and failure,
// with registered lane-enable, status and payload outputs.
import fsic_io_serdes_pkg::*;

module fsic_io_serdes_rx_link_ctrl #(
    parameter int                    pCLK_RATIO   = CLK_RATIO,
    parameter logic [pCLK_RATIO-1:0] pTRAIN_PAT   = TRAIN_PAT,
    parameter int                    pTRAIN_LEN   = 8,
    parameter int                    pSETTLE_CYC  = 6,
    parameter int                    pTIMEOUT_CYC = 64,
    parameter int                    pOFF_CYC     = 4,
    parameter int                    pMAX_RETRY   = 3
) (
    input  logic                  coreclk,
    input  logic                  axis_rst_n,
    input  logic                  ctrl_en,
    input  logic [pCLK_RATIO-1:0] rxdata_in,
    input  logic                  rxdata_in_valid,
    output logic                  rxen,
    output logic                  link_up,
    output logic                  link_fail,
    output logic [pCLK_RATIO-1:0] rx_word,
    output logic                  rx_word_valid,
    output logic [1:0]            retry_cnt
);

    localparam int TO_W   = $clog2(pTIMEOUT_CYC);
    localparam int PH_MAX = (pSETTLE_CYC > pOFF_CYC) ? pSETTLE_CYC : pOFF_CYC;
    localparam int PH_W   = $clog2(PH_MAX);
    localparam int MC_W   = $clog2(pTRAIN_LEN + 1);

    state_t                state_q, state_d;
    logic [PH_W-1:0]       ph_cnt_q, ph_cnt_d;
    logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
    logic [1:0]            retry_q, retry_d;
    logic                  rxen_q, link_up_q, link_fail_q, rx_word_valid_q;
    logic [pCLK_RATIO-1:0] rx_word_q;
    logic                  train_done_s, train_clr_s, train_en_s, fwd_s;
    logic [MC_W-1:0]       match_cnt_s;

    assign train_clr_s = !ctrl_en || (state_q != ST_TRAIN);
    assign train_en_s  = rxdata_in_valid && (state_q == ST_TRAIN);
    assign fwd_s       = ctrl_en && (state_q == ST_LINK) && rxdata_in_valid
                         && (rxdata_in != pTRAIN_PAT);

    fsic_io_serdes_train_chk #(
        .W   (pCLK_RATIO),
        .PAT (pTRAIN_PAT),
        .LEN (pTRAIN_LEN)
    ) u_train_chk (
        .clk_i       (coreclk),
        .rst_ni      (axis_rst_n),
        .clr_i       (train_clr_s),
        .en_i        (train_en_s),
        .word_i      (rxdata_in),
        .done_o      (train_done_s),
        .match_cnt_o (match_cnt_s)
    );

    // Next-state logic; to_cnt defaults to zero so it only runs while in TRAIN.
    always_comb begin
        state_d  = state_q;
        ph_cnt_d = ph_cnt_q;
        to_cnt_d = '0;
        retry_d  = retry_q;
        if (!ctrl_en) begin
            state_d  = ST_IDLE;
            ph_cnt_d = '0;
            retry_d  = 2'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d  = ST_SETTLE;
                    ph_cnt_d = '0;
                end
                ST_SETTLE: begin
                    if (ph_cnt_q == PH_W'(pSETTLE_CYC - 1)) begin
                        state_d  = ST_TRAIN;
                        ph_cnt_d = '0;
                    end else begin
                        ph_cnt_d = ph_cnt_q + PH_W'(1);
                    end
                end
                ST_TRAIN: begin
                    // Pattern completion takes priority over a coincident timeout.
                    if (train_done_s) begin
                        state_d = ST_LINK;
                    end else if (to_cnt_q == TO_W'(pTIMEOUT_CYC - 1)) begin
                        state_d = (retry_q == 2'(pMAX_RETRY)) ? ST_FAIL : ST_OFF;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_W'(1);
                    end
                end
                ST_LINK: begin
                    state_d = ST_LINK;
                end
                ST_OFF: begin
                    if (ph_cnt_q == PH_W'(pOFF_CYC - 1)) begin
                        state_d  = ST_SETTLE;
                        ph_cnt_d = '0;
                        retry_d  = sat_inc2(retry_q, 2'(pMAX_RETRY));
                    end else begin
                        ph_cnt_d = ph_cnt_q + PH_W'(1);
                    end
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d  = ST_IDLE;
                    ph_cnt_d = '0;
                    retry_d  = 2'd0;
                end
            endcase
        end
    end

    // State, counters and outputs; status outputs follow the state being entered.
    always_ff @(posedge coreclk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_q         <= ST_IDLE;
            ph_cnt_q        <= '0;
            to_cnt_q        <= '0;
            retry_q         <= 2'd0;
            rxen_q          <= 1'b0;
            link_up_q       <= 1'b0;
            link_fail_q     <= 1'b0;
            rx_word_valid_q <= 1'b0;
            rx_word_q       <= '0;
        end else begin
            state_q         <= state_d;
            ph_cnt_q        <= ph_cnt_d;
            to_cnt_q        <= to_cnt_d;
            retry_q         <= retry_d;
            rxen_q          <= (state_d == ST_SETTLE) || (state_d == ST_TRAIN)
                               || (state_d == ST_LINK);
            link_up_q       <= (state_d == ST_LINK);
            link_fail_q     <= (state_d == ST_FAIL);
            rx_word_valid_q <= fwd_s;
            if (fwd_s) begin
                rx_word_q <= rxdata_in;
            end else begin
                rx_word_q <= rx_word_q;
            end
        end
    end

    assign rxen          = rxen_q;
    assign link_up       = link_up_q;
    assign link_fail     = link_fail_q;
    assign rx_word       = rx_word_q;
    assign rx_word_valid = rx_word_valid_q;
    assign retry_cnt     = retry_q;

endmodule

// File: tb/tb_fsic_io_serdes_rx_link_ctrl.sv
// Self-checking bench for the rx link controller: directed scenarios plus
// randomized traffic compared against a phase/age behavioural model.
module tb_fsic_io_serdes_rx_link_ctrl;

    localparam int SETTLE = 6;
    localparam int LEN    = 8;
    localparam int TMO    = 64;
    localparam int OFFC   = 4;
    localparam int MAXR   = 3;

    localparam int P_IDLE = 0, P_SETTLE = 1, P_TRAIN = 2, P_LINK = 3, P_OFF = 4, P_FAIL = 5;

    logic       coreclk = 1'b0;
    logic       axis_rst_n;
    logic       ctrl_en;
    logic [3:0] rxdata_in;
    logic       rxdata_in_valid;
    logic       rxen, link_up, link_fail, rx_word_valid;
    logic [3:0] rx_word;
    logic [1:0] retry_cnt;

    int checks = 0;
    int errors = 0;

    int         m_phase, m_age, m_run, m_tries;
    logic       m_fwd_v;
    logic [3:0] m_fwd_w;

    wire [9:0] dut_obs = {rxen, link_up, link_fail, rx_word_valid, rx_word, retry_cnt};

    fsic_io_serdes_rx_link_ctrl dut (
        .coreclk         (coreclk),
        .axis_rst_n      (axis_rst_n),
        .ctrl_en         (ctrl_en),
        .rxdata_in       (rxdata_in),
        .rxdata_in_valid (rxdata_in_valid),
        .rxen            (rxen),
        .link_up         (link_up),
        .link_fail       (link_fail),
        .rx_word         (rx_word),
        .rx_word_valid   (rx_word_valid),
        .retry_cnt       (retry_cnt)
    );

    always #5 coreclk = ~coreclk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [9:0] mdl_obs();
        logic lane_on;
        lane_on = (m_phase == P_SETTLE) || (m_phase == P_TRAIN) || (m_phase == P_LINK);
        return {lane_on, m_phase == P_LINK, m_phase == P_FAIL, m_fwd_v, m_fwd_w, 2'(m_tries)};
    endfunction

    function automatic logic [3:0] junk();
        return 4'($urandom_range(0, 9));
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE; m_age = 0; m_run = 0; m_tries = 0;
        m_fwd_v = 1'b0;   m_fwd_w = 4'h0;
    endtask

    task automatic model_step();
        logic hit;
        hit = rxdata_in_valid && (rxdata_in == 4'hA);
        m_fwd_v = 1'b0;
        if (!ctrl_en) begin
            m_phase = P_IDLE; m_age = 0; m_run = 0; m_tries = 0;
        end else begin
            case (m_phase)
                P_IDLE: begin m_phase = P_SETTLE; m_age = 0; end
                P_SETTLE: begin
                    m_age++;
                    if (m_age == SETTLE) begin m_phase = P_TRAIN; m_age = 0; m_run = 0; end
                end
                P_TRAIN: begin
                    if (hit) m_run = (m_run < LEN) ? m_run + 1 : m_run;
                    else if (rxdata_in_valid) m_run = 0;
                    if (m_run == LEN) m_phase = P_LINK;
                    else if (m_age == TMO - 1) begin
                        m_phase = (m_tries == MAXR) ? P_FAIL : P_OFF;
                        m_age = 0;
                    end else m_age++;
                end
                P_LINK: if (rxdata_in_valid && !hit) begin m_fwd_v = 1'b1; m_fwd_w = rxdata_in; end
                P_OFF: begin
                    m_age++;
                    if (m_age == OFFC) begin
                        m_tries = (m_tries < MAXR) ? m_tries + 1 : m_tries;
                        m_phase = P_SETTLE; m_age = 0;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic tick();
        @(posedge coreclk);
        model_step();
        #1;
    endtask

    task automatic cleanup();
        ctrl_en = 1'b0; rxdata_in_valid = 1'b0; rxdata_in = 4'h0;
        tick(); tick();
    endtask

    task automatic test_reset();
        axis_rst_n = 1'b0; ctrl_en = 1'b0; rxdata_in = 4'h0; rxdata_in_valid = 1'b0;
        model_reset();
        #23;
        checks++;
        if (dut_obs !== 10'h000) begin
            errors++; $display("FAIL reset_values: got %h want %h", dut_obs, 10'h000);
        end
        axis_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (dut_obs !== mdl_obs()) begin
                errors++; $display("FAIL reset_idle c%0d: got %h want %h", i, dut_obs, mdl_obs());
            end
        end
    endtask

    task automatic test_bringup();
        logic [3:0] q[$];
        cleanup();
        ctrl_en = 1'b1;
        for (int i = 0; i < 7; i++) q.push_back(junk());
        for (int i = 0; i < 8; i++) q.push_back(4'hA);
        q.push_back(4'h3); q.push_back(4'h5); q.push_back(4'hA); q.push_back(4'hA);
        foreach (q[i]) begin
            rxdata_in = q[i]; rxdata_in_valid = 1'b1;
            tick();
            checks++;
            if (dut_obs !== mdl_obs()) begin
                errors++; $display("FAIL bringup c%0d: got %h want %h", i, dut_obs, mdl_obs());
            end
            if (i == 13) begin
                checks++;
                if (link_up !== 1'b0) begin errors++; $display("FAIL bringup_early_link: got %b want 0", link_up); end
            end
            if (i == 14) begin
                checks++;
                if (link_up !== 1'b1) begin errors++; $display("FAIL bringup_link_up: got %b want 1", link_up); end
            end
            if (i == 15 || i == 16) begin
                checks++;
                if ({rx_word_valid, rx_word} !== {1'b1, q[i]}) begin
                    errors++; $display("FAIL bringup_payload c%0d: got %b/%h want 1/%h", i, rx_word_valid, rx_word, q[i]);
                end
            end
            if (i == 17) begin
                checks++;
                if (rx_word_valid !== 1'b0) begin errors++; $display("FAIL bringup_drop_train: got %b want 0", rx_word_valid); end
            end
        end
    endtask

    task automatic test_mismatch();
        logic [3:0] q[$];
        cleanup();
        ctrl_en = 1'b1;
        for (int i = 0; i < 7; i++) q.push_back(junk());
        for (int i = 0; i < 5; i++) q.push_back(4'hA);
        q.push_back(4'h0);
        for (int i = 0; i < 8; i++) q.push_back(4'hA);
        q.push_back(4'h7);
        foreach (q[i]) begin
            rxdata_in = q[i]; rxdata_in_valid = 1'b1;
            tick();
            checks++;
            if (dut_obs !== mdl_obs()) begin
                errors++; $display("FAIL mismatch c%0d: got %h want %h", i, dut_obs, mdl_obs());
            end
            if (i == 19 || i == 20) begin
                checks++;
                if ({link_up, retry_cnt} !== {(i == 20), 2'd0}) begin
                    errors++; $display("FAIL mismatch_restart c%0d: got %b/%0d want %b/0", i, link_up, retry_cnt, (i == 20));
                end
            end
        end
    endtask

    task automatic test_timeout_fail();
        int n, low, fail_at;
        cleanup();
        ctrl_en = 1'b1; rxdata_in = 4'h0; rxdata_in_valid = 1'b1;
        n = 0; low = 0; fail_at = -1;
        while (n < 400 && fail_at < 0) begin
            tick(); n++;
            checks++;
            if (dut_obs !== mdl_obs()) begin
                errors++; $display("FAIL timeout c%0d: got %h want %h", n, dut_obs, mdl_obs());
            end
            if (link_fail === 1'b1) fail_at = n;
            else if (rxen === 1'b0 && n > 1) low++;
        end
        checks++;
        if (fail_at !== 1 + 4 * (SETTLE + TMO) + MAXR * OFFC) begin
            errors++; $display("FAIL timeout_fail_cycle: got %0d want %0d", fail_at, 1 + 4 * (SETTLE + TMO) + MAXR * OFFC);
        end
        checks++;
        if (low !== MAXR * OFFC) begin
            errors++; $display("FAIL timeout_off_cycles: got %0d want %0d", low, MAXR * OFFC);
        end
        tick();
        checks++;
        if ({link_fail, rxen, retry_cnt} !== {1'b1, 1'b0, 2'd3}) begin
            errors++; $display("FAIL timeout_fail_hold: got %b%b/%0d want 10/3", link_fail, rxen, retry_cnt);
        end
    endtask

    task automatic test_ctrl_drop();
        cleanup();
        ctrl_en = 1'b1; rxdata_in_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin rxdata_in = junk(); tick(); end
        for (int i = 0; i < 8; i++) begin rxdata_in = 4'hA; tick(); end
        for (int i = 0; i < 6; i++) begin
            rxdata_in = 4'($urandom_range(0, 15));
            tick();
            checks++;
            if (dut_obs !== mdl_obs()) begin
                errors++; $display("FAIL ctrldrop_link c%0d: got %h want %h", i, dut_obs, mdl_obs());
            end
        end
        ctrl_en = 1'b0; rxdata_in = 4'h6;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({rxen, link_up, rx_word_valid, retry_cnt} !== 5'b00000) begin
                errors++; $display("FAIL ctrldrop_off c%0d: got %b%b%b/%0d want 000/0", i, rxen, link_up, rx_word_valid, retry_cnt);
            end
        end
        ctrl_en = 1'b1;
        tick();
        checks++;
        if ({rxen, link_up} !== 2'b10 || dut_obs !== mdl_obs()) begin
            errors++; $display("FAIL ctrldrop_restart: got %h want %h", dut_obs, mdl_obs());
        end
    endtask

    task automatic test_async_reset();
        cleanup();
        ctrl_en = 1'b1; rxdata_in = 4'h0; rxdata_in_valid = 1'b1;
        for (int k = 0; k < 400 && !(m_tries == 2 && m_phase == P_TRAIN && m_age == 20); k++) tick();
        checks++;
        if (retry_cnt !== 2'd2 || rxen !== 1'b1) begin
            errors++; $display("FAIL areset_pre: got %0d/%b want 2/1", retry_cnt, rxen);
        end
        #3 axis_rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (dut_obs !== 10'h000) begin errors++; $display("FAIL areset_train: got %h want 000", dut_obs); end
        @(negedge coreclk);
        axis_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (dut_obs !== mdl_obs()) begin
                errors++; $display("FAIL areset_release c%0d: got %h want %h", i, dut_obs, mdl_obs());
            end
        end
        for (int k = 0; k < 20 && m_phase != P_TRAIN; k++) begin rxdata_in = junk(); tick(); end
        for (int i = 0; i < 8; i++) begin rxdata_in = 4'hA; tick(); end
        rxdata_in = 4'h9;
        tick();
        checks++;
        if ({link_up, rx_word_valid} !== 2'b11) begin
            errors++; $display("FAIL areset_link_pre: got %b%b want 11", link_up, rx_word_valid);
        end
        #2 axis_rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (dut_obs !== 10'h000) begin errors++; $display("FAIL areset_link: got %h want 000", dut_obs); end
        @(negedge coreclk);
        axis_rst_n = 1'b1;
    endtask

    task automatic test_late_link();
        cleanup();
        ctrl_en = 1'b1; rxdata_in_valid = 1'b1;
        for (int k = 0; k < 20 && m_phase != P_TRAIN; k++) begin rxdata_in = junk(); tick(); end
        for (int i = 0; i < TMO; i++) begin
            rxdata_in = (i >= TMO - LEN) ? 4'hA : junk();
            tick();
            checks++;
            if (dut_obs !== mdl_obs()) begin
                errors++; $display("FAIL latelink c%0d: got %h want %h", i, dut_obs, mdl_obs());
            end
        end
        checks++;
        if ({link_up, rxen, retry_cnt} !== {2'b11, 2'd0}) begin
            errors++; $display("FAIL latelink_state: got %b%b/%0d want 11/0", link_up, rxen, retry_cnt);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 5; it++) begin
            int vstart;
            cleanup();
            ctrl_en = 1'b1;
            vstart = $urandom_range(1, 10);
            for (int c = 0; c < 220; c++) begin
                if ($urandom_range(0, 99) == 0) ctrl_en = ~ctrl_en;
                if (c == vstart) rxdata_in_valid = 1'b1;
                rxdata_in = ($urandom_range(0, 99) < 80) ? 4'hA : 4'($urandom_range(0, 15));
                tick();
                checks++;
                if (dut_obs !== mdl_obs()) begin
                    errors++; $display("FAIL random i%0d c%0d: got %h want %h", it, c, dut_obs, mdl_obs());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_mismatch();
        test_timeout_fail();
        test_ctrl_drop();
        test_async_reset();
        test_late_link();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
